// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures the decode control word and operands for EX; holds on ext_stall, bubbles on flush or load-use.
module id_ex_reg #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          ext_stall,
  input  logic [1:0]    jump_in,
  input  logic          branch_in,
  input  logic          mem_read_in,
  input  logic [1:0]    mem_to_reg_in,
  input  logic          mem_write_in,
  input  logic          alu_src_in,
  input  logic          reg_write_in,
  input  logic [1:0]    reg_dst_in,
  input  logic [3:0]    alu_op_in,
  input  logic [DW-1:0] pc_in,
  input  logic [DW-1:0] rs_data_in,
  input  logic [DW-1:0] rt_data_in,
  input  logic [DW-1:0] imm_in,
  input  logic [RW-1:0] rs_in,
  input  logic [RW-1:0] rt_in,
  input  logic [RW-1:0] rd_in,
  output logic [1:0]    jump_out,
  output logic          branch_out,
  output logic          mem_read_out,
  output logic [1:0]    mem_to_reg_out,
  output logic          mem_write_out,
  output logic          alu_src_out,
  output logic          reg_write_out,
  output logic [1:0]    reg_dst_out,
  output logic [3:0]    alu_op_out,
  output logic [DW-1:0] pc_out,
  output logic [DW-1:0] rs_data_out,
  output logic [DW-1:0] rt_data_out,
  output logic [DW-1:0] imm_out,
  output logic [RW-1:0] rs_out,
  output logic [RW-1:0] rt_out,
  output logic [RW-1:0] rd_out,
  output logic          valid_out,
  output logic          hazard_stall
);

  // Load in EX whose destination feeds the ID instruction. Conservative: both
  // source specifiers are compared whatever the instruction format. Not gated
  // by flush/ext_stall; upstream combines those.
  assign hazard_stall = valid_out & mem_read_out & (rt_out != '0) &
                        ((rt_out == rs_in) | (rt_out == rt_in));

  always_ff @(posedge clk) begin
    if (rst || flush || (!ext_stall && hazard_stall)) begin
      // Reset and bubble share the all-zero word, which decodes as a NOP.
      jump_out       <= '0;
      branch_out     <= 1'b0;
      mem_read_out   <= 1'b0;
      mem_to_reg_out <= '0;
      mem_write_out  <= 1'b0;
      alu_src_out    <= 1'b0;
      reg_write_out  <= 1'b0;
      reg_dst_out    <= '0;
      alu_op_out     <= '0;
      pc_out         <= '0;
      rs_data_out    <= '0;
      rt_data_out    <= '0;
      imm_out        <= '0;
      rs_out         <= '0;
      rt_out         <= '0;
      rd_out         <= '0;
      valid_out      <= 1'b0;
    end else if (!ext_stall) begin
      jump_out       <= jump_in;
      branch_out     <= branch_in;
      mem_read_out   <= mem_read_in;
      mem_to_reg_out <= mem_to_reg_in;
      mem_write_out  <= mem_write_in;
      alu_src_out    <= alu_src_in;
      reg_write_out  <= reg_write_in;
      reg_dst_out    <= reg_dst_in;
      alu_op_out     <= alu_op_in;
      pc_out         <= pc_in;
      rs_data_out    <= rs_data_in;
      rt_data_out    <= rt_data_in;
      imm_out        <= imm_in;
      rs_out         <= rs_in;
      rt_out         <= rt_in;
      rd_out         <= rd_in;
      valid_out      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: a reference model predicts each cycle's
// register contents into a queue, popped and compared after the clock edge.
module tb_id_ex_reg;

  typedef struct packed {
    logic [1:0]  jump;
    logic        branch;
    logic        mem_read;
    logic [1:0]  mem_to_reg;
    logic        mem_write;
    logic        alu_src;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic [3:0]  alu_op;
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        valid;
  } word_t;

  localparam int W = $bits(word_t);

  logic        clk, rst, flush, ext_stall;
  logic [1:0]  jump_in, mem_to_reg_in, reg_dst_in;
  logic        branch_in, mem_read_in, mem_write_in, alu_src_in, reg_write_in;
  logic [3:0]  alu_op_in;
  logic [31:0] pc_in, rs_data_in, rt_data_in, imm_in;
  logic [4:0]  rs_in, rt_in, rd_in;
  logic [1:0]  jump_out, mem_to_reg_out, reg_dst_out;
  logic        branch_out, mem_read_out, mem_write_out, alu_src_out, reg_write_out;
  logic [3:0]  alu_op_out;
  logic [31:0] pc_out, rs_data_out, rt_data_out, imm_out;
  logic [4:0]  rs_out, rt_out, rd_out;
  logic        valid_out, hazard_stall;

  word_t dut_w, in_w, model;
  logic [W-1:0] exp_q[$];
  int n_compared = 0;
  int n_mismatched = 0;

  id_ex_reg #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ext_stall(ext_stall),
    .jump_in(jump_in), .branch_in(branch_in), .mem_read_in(mem_read_in),
    .mem_to_reg_in(mem_to_reg_in), .mem_write_in(mem_write_in),
    .alu_src_in(alu_src_in), .reg_write_in(reg_write_in), .reg_dst_in(reg_dst_in),
    .alu_op_in(alu_op_in), .pc_in(pc_in), .rs_data_in(rs_data_in),
    .rt_data_in(rt_data_in), .imm_in(imm_in), .rs_in(rs_in), .rt_in(rt_in),
    .rd_in(rd_in),
    .jump_out(jump_out), .branch_out(branch_out), .mem_read_out(mem_read_out),
    .mem_to_reg_out(mem_to_reg_out), .mem_write_out(mem_write_out),
    .alu_src_out(alu_src_out), .reg_write_out(reg_write_out),
    .reg_dst_out(reg_dst_out), .alu_op_out(alu_op_out), .pc_out(pc_out),
    .rs_data_out(rs_data_out), .rt_data_out(rt_data_out), .imm_out(imm_out),
    .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
    .valid_out(valid_out), .hazard_stall(hazard_stall)
  );

  assign dut_w = {jump_out, branch_out, mem_read_out, mem_to_reg_out, mem_write_out,
                  alu_src_out, reg_write_out, reg_dst_out, alu_op_out, pc_out,
                  rs_data_out, rt_data_out, imm_out, rs_out, rt_out, rd_out, valid_out};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver
  task automatic apply(input word_t w);
    in_w          = w;
    in_w.valid    = 1'b1;
    jump_in       = w.jump;
    branch_in     = w.branch;
    mem_read_in   = w.mem_read;
    mem_to_reg_in = w.mem_to_reg;
    mem_write_in  = w.mem_write;
    alu_src_in    = w.alu_src;
    reg_write_in  = w.reg_write;
    reg_dst_in    = w.reg_dst;
    alu_op_in     = w.alu_op;
    pc_in         = w.pc;
    rs_data_in    = w.rs_data;
    rt_data_in    = w.rt_data;
    imm_in        = w.imm;
    rs_in         = w.rs;
    rt_in         = w.rt;
    rd_in         = w.rd;
  endtask

  function automatic word_t rand_word();
    word_t w;
    w            = word_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
    w.rs         = 5'($urandom_range(0, 3));
    w.rt         = 5'($urandom_range(0, 3));
    w.valid      = 1'b1;
    return w;
  endfunction

  // One clock: check the combinational hazard, predict, clock, compare.
  task automatic step(input string tag);
    logic exp_h;
    logic [W-1:0] exp;
    #1;
    exp_h = model.valid & model.mem_read & (model.rt != 5'd0) &
            ((model.rt == rs_in) | (model.rt == rt_in));
    check({tag, "_hazard"}, W'(hazard_stall), W'(exp_h));
    if (rst || flush)        model = '0;
    else if (ext_stall)      model = model;
    else if (exp_h)          model = '0;
    else                     model = in_w;
    exp_q.push_back(model);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL %s: scoreboard queue empty", tag);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_regs"}, dut_w, exp);
    end
  endtask

  word_t w;

  initial begin
    rst = 1'b1; flush = 1'b0; ext_stall = 1'b0;
    apply('0);
    @(posedge clk);
    @(posedge clk);
    #1;
    model = '0;
    check("reset_regs", dut_w, '0);
    check("reset_hazard", W'(hazard_stall), '0);
    rst = 1'b0;

    // Reset from a fully-loaded state with all inputs high
    apply('1);
    step("load_ones");
    rst = 1'b1;
    step("reset_ones");
    check("reset_ones_hz_after", W'(hazard_stall), '0);
    rst = 1'b0;

    // Pass-through
    w = '0; w.alu_op = 4'h2; w.reg_write = 1'b1; w.pc = 32'h0000_0404; w.rd = 5'd8;
    apply(w);
    step("pass");
    check("pass_alu_op", W'(alu_op_out), W'(4'h2));
    check("pass_pc", W'(pc_out), W'(32'h404));
    check("pass_valid", W'(valid_out), W'(1'b1));

    // Load-use: lw $9 in EX, then consumer with rs=9
    w = '0; w.mem_read = 1'b1; w.rt = 5'd9; w.reg_write = 1'b1;
    apply(w);
    step("lw9");
    w = '0; w.rs = 5'd9; w.rt = 5'd3; w.alu_op = 4'h5;
    apply(w);
    check("lu_hazard_hi", W'(hazard_stall), W'(1'b1));
    step("lu_bubble");
    check("lu_bubble_valid", W'(valid_out), '0);
    check("lu_hazard_lo", W'(hazard_stall), '0);
    step("lu_retry");
    // Load to $0 never stalls
    w = '0; w.mem_read = 1'b1; w.rt = 5'd0;
    apply(w);
    step("lw0");
    w = '0; w.rs = 5'd0; w.rt = 5'd0;
    apply(w);
    step("lw0_use");

    // Hold for three cycles while inputs change, then release
    w = rand_word(); w.reg_write = 1'b1; w.mem_read = 1'b0;
    apply(w);
    step("pre_hold");
    ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(rand_word());
      step("hold");
    end
    ext_stall = 1'b0;
    w = rand_word(); w.mem_read = 1'b0; w.reg_write = 1'b1;
    apply(w);
    step("release");

    // Flush beats ext_stall
    flush = 1'b1; ext_stall = 1'b1;
    apply(rand_word());
    step("flush_stall");
    check("flush_valid", W'(valid_out), '0);
    flush = 1'b0; ext_stall = 1'b0;

    // ext_stall holds over a pending hazard; bubble after release
    w = '0; w.mem_read = 1'b1; w.rt = 5'd7;
    apply(w);
    step("lw7");
    w = '0; w.rt = 5'd7; w.rs = 5'd1;
    apply(w);
    ext_stall = 1'b1;
    step("sh_hold1");
    check("sh_hazard_held", W'(hazard_stall), W'(1'b1));
    step("sh_hold2");
    ext_stall = 1'b0;
    step("sh_bubble");
    check("sh_bubble_valid", W'(valid_out), '0);

    // Back-to-back independent loads: full throughput
    for (int i = 1; i <= 4; i++) begin
      w = rand_word(); w.mem_read = 1'b1;
      w.rt = 5'(10 + i); w.rs = 5'(20 + i);
      apply(w);
      step("b2b_lw");
      check("b2b_valid", W'(valid_out), W'(1'b1));
    end

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      rst       = ($urandom_range(0, 39) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      ext_stall = ($urandom_range(0, 5) == 0);
      apply(rand_word());
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

ID/EX pipeline register for the MIPS32 core. It latches the decode-stage control word produced by `ctrl`, together with register-file read data, the immediate, PC+4 and register specifiers, and presents them to the EX stage one cycle later. It holds its contents on downstream stall and inserts a bubble on flush. It also contains the load-use hazard detector, which stalls the IF/ID stage and injects a bubble when a load in EX feeds the instruction in ID.

## Interface
Parameters:
- `DW`, default 32: data/PC/immediate width.
- `RW`, default 5: register-specifier width.

Ports:
- `clk`  in  1: rising-edge clock. One clock domain only.
- `rst`  in  1: reset, synchronous, active-high.
- `flush`  in  1: kill the ID instruction (taken branch/jump resolved downstream).
- `ext_stall`  in  1: downstream stall; hold all contents.
- `jump_in`  in  2: from ctrl.
- `branch_in`  in  1: from ctrl.
- `mem_read_in`  in  1: from ctrl.
- `mem_to_reg_in`  in  2: from ctrl.
- `mem_write_in`  in  1: from ctrl.
- `alu_src_in`  in  1: from ctrl.
- `reg_write_in`  in  1: from ctrl.
- `reg_dst_in`  in  2: from ctrl.
- `alu_op_in`  in  4: from ctrl.
- `pc_in`  in  DW: PC+4 of the ID instruction.
- `rs_data_in`, `rt_data_in`  in  DW each: register-file read data.
- `imm_in`  in  DW: sign/zero-extended immediate.
- `rs_in`, `rt_in`, `rd_in`  in  RW each: register specifiers of the ID instruction.
- `<name>_out`  out  (same width as the input): registered copy of every `*_in` above.
- `valid_out`  out  1: EX slot holds a real instruction.
- `hazard_stall`  out  1: combinational; IF/ID and PC must hold this cycle.

## Operation
- Register update at each rising `clk` edge, in strict priority order:
  1. `rst`: every output register is cleared to 0.
  2. `flush`: bubble. Applies even when `ext_stall` is high.
  3. `ext_stall`: hold every register unchanged.
  4. `hazard_stall`: bubble.
  5. Otherwise, load: every `*_out` takes its `*_in`, and `valid_out` is set to 1.
- Bubble: all `*_out` fields and `valid_out` are set to 0. A zero control word is a NOP: no register write, no memory access, no branch or jump.
- Hazard detect: `hazard_stall` = `valid_out` & `mem_read_out` & (`rt_out` != 0) & ((`rt_out` == `rs_in`) | (`rt_out` == `rt_in`)).
  - The comparison is conservative: both `rs_in` and `rt_in` are compared regardless of instruction format.
- `hazard_stall` is a function of registered state and `rs_in`/`rt_in` only. It has no path from `flush` or `ext_stall`. Upstream is responsible for gating it with those signals.
- After a hazard bubble, `valid_out` = 0, so `hazard_stall` deasserts the next cycle. A load-use stall therefore lasts exactly one cycle.
- No arithmetic is performed; all fields are passed through bit-exact.

## Timing
- Latency: 1 cycle from `*_in` to `*_out`.
- `hazard_stall` is valid in the same cycle that `rs_in`/`rt_in` change. There is no registered delay.
- Reset values: every `*_out` = 0, `valid_out` = 0, and therefore `hazard_stall` = 0 in the first cycle after reset.
- Reset mid-operation: in-flight contents are discarded; there is no partial retention.
- Simultaneous `flush` and `ext_stall`: bubble is written; flush wins.
- Simultaneous `ext_stall` and `hazard_stall`: hold; no bubble is written. The hazard re-evaluates after the stall releases.
- Back-to-back loads with no dependency: no stall, full throughput of one instruction per cycle.

## Test plan
- Reset: drive all inputs high, pulse `rst` for 1 cycle -> every output is 0, `valid_out` = 0, `hazard_stall` = 0.
- Pass-through: `alu_op_in` = 4'h2, `reg_write_in` = 1, `pc_in` = 32'h0000_0404, `rd_in` = 5'd8 -> the next cycle `alu_op_out` = 2, `reg_write_out` = 1, `pc_out` = 0x404, `rd_out` = 8, `valid_out` = 1.
- Load-use: EX holds `lw` with `mem_read_out` = 1, `rt_out` = 5'd9; then `rs_in` = 9 -> `hazard_stall` = 1 in that cycle, a bubble is written (`valid_out` = 0), and `hazard_stall` = 0 the following cycle. Repeat with `rt_out` = 0 -> no stall.
- Hold: assert `ext_stall` for 3 cycles while the inputs change -> all outputs stay frozen at their pre-stall values. After release, the current inputs load on the next edge.
- Flush priority: `flush` = 1 and `ext_stall` = 1 with `reg_write_out` = 1 previously -> the next cycle all outputs are 0 and `valid_out` = 0.
- Stall vs hazard: load-use condition true and `ext_stall` = 1 -> contents held and `hazard_stall` = 1. After `ext_stall` drops, the bubble is written on the next edge.
